// File: rtl/data_memory_stack_unit.sv
// rtl/data_memory_stack_unit.sv - word-addressed data memory with an embedded hardware stack region
module data_memory_stack_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_WORDS   = 256,
    parameter int STACK_BASE  = 200,
    parameter int STACK_WORDS = 56
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               mem_write,
    input  logic                               mem_read,
    input  logic                               stack_en,
    input  logic [ADDR_W-1:0]                  address,
    input  logic [DATA_W-1:0]                  data_in,
    input  logic                               err_clear,
    output logic [DATA_W-1:0]                  data_out,
    output logic                               data_valid,
    output logic [$clog2(STACK_WORDS+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_overflow,
    output logic                               stack_underflow,
    output logic                               addr_error
);
    localparam int SP_W  = $clog2(STACK_WORDS+1);
    localparam int IDX_W = $clog2(MEM_WORDS);

    // Power-up image: words 0..2 hold 2,1,0; reset never touches the array.
    logic [DATA_W-1:0] mem [MEM_WORDS] = '{0: DATA_W'(2), 1: DATA_W'(1), default: DATA_W'(0)};

    logic             addr_bad;
    logic [IDX_W-1:0] static_idx, push_idx, top_idx;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_en, rd_en, rd_zero;
    logic [SP_W-1:0]  sp_next;
    logic             set_ovf, set_udf, set_addr;

    assign stack_full  = (sp == SP_W'(STACK_WORDS));
    assign stack_empty = (sp == '0);

    assign addr_bad   = (address[1:0] != 2'b00) ||
                        ({2'b00, address[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
    assign static_idx = address[IDX_W+1:2];
    assign push_idx   = IDX_W'(STACK_BASE) + IDX_W'(sp);
    assign top_idx    = push_idx - 1'b1;

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = static_idx;
        rd_en    = 1'b0;
        rd_zero  = 1'b0;
        rd_idx   = static_idx;
        sp_next  = sp;
        set_ovf  = 1'b0;
        set_udf  = 1'b0;
        set_addr = 1'b0;
        if (!stack_en) begin
            if (mem_read || mem_write) begin
                if (addr_bad) begin
                    rd_en    = 1'b1;
                    rd_zero  = 1'b1;
                    set_addr = 1'b1;
                end else begin
                    rd_en = mem_read;
                    wr_en = mem_write;
                end
            end
        end else if (mem_write && !mem_read) begin
            if (stack_full) begin
                set_ovf = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = push_idx;
                sp_next = sp + 1'b1;
            end
        end else if (mem_read) begin
            rd_en = 1'b1;
            if (stack_empty) begin
                rd_zero = 1'b1;
                set_udf = 1'b1;
            end else begin
                rd_idx = top_idx;
                // push+pop swaps the top word in place and leaves sp alone
                if (mem_write) begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    sp_next = sp - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out        <= '0;
            data_valid      <= 1'b0;
            sp              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            addr_error      <= 1'b0;
        end else begin
            data_valid <= rd_en;
            if (rd_en) begin
                data_out <= rd_zero ? '0 : mem[rd_idx];
            end
            sp              <= sp_next;
            stack_overflow  <= (stack_overflow  & ~err_clear) | set_ovf;
            stack_underflow <= (stack_underflow & ~err_clear) | set_udf;
            addr_error      <= (addr_error      & ~err_clear) | set_addr;
        end
    end
endmodule

// File: tb/tb_data_memory_stack_unit.sv
// tb/tb_data_memory_stack_unit.sv - directed self-checking bench for data_memory_stack_unit
module tb_data_memory_stack_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        stack_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic        err_clear = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic [5:0]  sp;
    logic        stack_full, stack_empty, stack_overflow, stack_underflow, addr_error;

    int n_cmp = 0;
    int n_fail = 0;

    data_memory_stack_unit dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .stack_en(stack_en), .address(address), .data_in(data_in), .err_clear(err_clear),
        .data_out(data_out), .data_valid(data_valid), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
        .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    // Apply one request for one rising edge; returns at the following falling edge.
    task automatic step(input logic w, input logic r, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
        mem_write = w; mem_read = r; stack_en = s; address = a; data_in = d;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b0; reset = 1'b0; err_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(1, 0, 1, 0, 32'h5A);
        reset = 1'b1; step(0, 0, 0, 0, 0);
        n_cmp++; if (sp !== 6'd0) begin n_fail++; $display("FAIL reset_sp got %0d exp 0", sp); end
        n_cmp++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", data_valid); end
        n_cmp++; if ({stack_overflow, stack_underflow, addr_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {stack_overflow, stack_underflow, addr_error}); end
        n_cmp++; if ({stack_full, stack_empty} !== 2'b01) begin n_fail++; $display("FAIL reset_full_empty got %b exp 01", {stack_full, stack_empty}); end
    endtask

    task automatic test_static_read();
        step(0, 1, 0, 32'h4, 0);
        n_cmp++; if ({data_valid, data_out} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL rd_addr4 got %b/%h exp 1/1", data_valid, data_out); end
        step(0, 1, 0, 32'h8, 0);
        n_cmp++; if ({data_valid, data_out} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL rd_addr8 got %b/%h exp 1/0", data_valid, data_out); end
        step(0, 1, 0, 32'h0, 0);
        n_cmp++; if ({data_valid, data_out} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL rd_addr0 got %b/%h exp 1/2", data_valid, data_out); end
        step(0, 0, 0, 32'h4, 0);
        n_cmp++; if ({data_valid, data_out} !== {1'b0, 32'd2}) begin n_fail++; $display("FAIL idle_hold got %b/%h exp 0/2", data_valid, data_out); end
    endtask

    task automatic test_static_write();
        step(1, 0, 0, 32'h10, 32'h1234);
        n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_valid got %b exp 0", data_valid); end
        step(0, 1, 0, 32'h10, 0);
        n_cmp++; if (data_out !== 32'h1234) begin n_fail++; $display("FAIL wr_readback got %h exp 1234", data_out); end
        step(1, 1, 0, 32'h10, 32'h5678);
        n_cmp++; if ({data_valid, data_out} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL rbw_old got %b/%h exp 1/1234", data_valid, data_out); end
        step(0, 1, 0, 32'h10, 0);
        n_cmp++; if (data_out !== 32'h5678) begin n_fail++; $display("FAIL rbw_new got %h exp 5678", data_out); end
        step(1, 0, 1, 0, 32'hAA);
        step(1, 0, 0, 32'h320, 32'hBB);
        n_cmp++; if (sp !== 6'd1) begin n_fail++; $display("FAIL static_in_stack_sp got %0d exp 1", sp); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({data_out, sp} !== {32'hBB, 6'd0}) begin n_fail++; $display("FAIL static_in_stack_pop got %h/%0d exp bb/0", data_out, sp); end
    endtask

    task automatic test_push_pop();
        step(1, 0, 1, 0, 32'hA);
        step(1, 0, 1, 0, 32'hB);
        step(1, 0, 1, 0, 32'hC);
        n_cmp++; if (sp !== 6'd3) begin n_fail++; $display("FAIL push3_sp got %0d exp 3", sp); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({data_valid, data_out, sp} !== {1'b1, 32'hC, 6'd2}) begin n_fail++; $display("FAIL pop1 got %b/%h/%0d exp 1/c/2", data_valid, data_out, sp); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({data_valid, data_out, sp} !== {1'b1, 32'hB, 6'd1}) begin n_fail++; $display("FAIL pop2 got %b/%h/%0d exp 1/b/1", data_valid, data_out, sp); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({data_valid, data_out, sp} !== {1'b1, 32'hA, 6'd0}) begin n_fail++; $display("FAIL pop3 got %b/%h/%0d exp 1/a/0", data_valid, data_out, sp); end
        n_cmp++; if (stack_empty !== 1'b1) begin n_fail++; $display("FAIL pop3_empty got %b exp 1", stack_empty); end
    endtask

    task automatic test_overflow();
        reset = 1'b1; step(0, 0, 0, 0, 0);
        for (int i = 0; i < 56; i++) step(1, 0, 1, 0, 32'h100 + i);
        n_cmp++; if ({stack_full, sp} !== {1'b1, 6'd56}) begin n_fail++; $display("FAIL fill got %b/%0d exp 1/56", stack_full, sp); end
        step(1, 0, 1, 0, 32'hDEAD);
        n_cmp++; if ({stack_overflow, sp} !== {1'b1, 6'd56}) begin n_fail++; $display("FAIL ovf got %b/%0d exp 1/56", stack_overflow, sp); end
        step(0, 1, 0, 32'h3FC, 0);
        n_cmp++; if (data_out !== 32'h137) begin n_fail++; $display("FAIL ovf_word255 got %h exp 137", data_out); end
        err_clear = 1'b1; step(1, 0, 1, 0, 32'hBEEF);
        n_cmp++; if (stack_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clear_vs_set got %b exp 1", stack_overflow); end
        err_clear = 1'b1; step(0, 0, 0, 0, 0);
        n_cmp++; if (stack_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", stack_overflow); end
        step(0, 1, 0, 32'h0, 0);
        n_cmp++; if (data_out !== 32'd2) begin n_fail++; $display("FAIL ovf_word0 got %h exp 2", data_out); end
    endtask

    task automatic test_underflow();
        reset = 1'b1; step(0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h4, 0);
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({stack_underflow, data_valid, data_out, sp} !== {1'b1, 1'b1, 32'h0, 6'd0}) begin n_fail++; $display("FAIL udf got %b/%b/%h/%0d exp 1/1/0/0", stack_underflow, data_valid, data_out, sp); end
        err_clear = 1'b1; step(0, 0, 0, 0, 0);
        n_cmp++; if (stack_underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear got %b exp 0", stack_underflow); end
        step(1, 1, 1, 0, 32'h99);
        n_cmp++; if ({stack_underflow, data_valid, data_out, sp} !== {1'b1, 1'b1, 32'h0, 6'd0}) begin n_fail++; $display("FAIL pushpop_empty got %b/%b/%h/%0d exp 1/1/0/0", stack_underflow, data_valid, data_out, sp); end
        step(0, 1, 0, 32'h320, 0);
        n_cmp++; if (data_out !== 32'h100) begin n_fail++; $display("FAIL pushpop_empty_nowrite got %h exp 100", data_out); end
    endtask

    task automatic test_push_pop_same();
        reset = 1'b1; step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 32'h11);
        step(1, 0, 1, 0, 32'h22);
        step(1, 1, 1, 0, 32'h33);
        n_cmp++; if ({data_valid, data_out, sp} !== {1'b1, 32'h22, 6'd2}) begin n_fail++; $display("FAIL swap got %b/%h/%0d exp 1/22/2", data_valid, data_out, sp); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({data_out, sp} !== {32'h33, 6'd1}) begin n_fail++; $display("FAIL swap_pop got %h/%0d exp 33/1", data_out, sp); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if ({data_out, sp} !== {32'h11, 6'd0}) begin n_fail++; $display("FAIL swap_pop2 got %h/%0d exp 11/0", data_out, sp); end
    endtask

    task automatic test_addr_error();
        step(1, 0, 0, 32'h401, 32'hBAD);
        n_cmp++; if ({addr_error, data_valid, data_out} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL aerr_401 got %b/%b/%h exp 1/1/0", addr_error, data_valid, data_out); end
        err_clear = 1'b1; step(0, 0, 0, 0, 0);
        n_cmp++; if (addr_error !== 1'b0) begin n_fail++; $display("FAIL aerr_clear got %b exp 0", addr_error); end
        step(1, 0, 0, 32'h400, 32'hBAD);
        n_cmp++; if (addr_error !== 1'b1) begin n_fail++; $display("FAIL aerr_400 got %b exp 1", addr_error); end
        step(0, 1, 0, 32'h0, 0);
        n_cmp++; if ({addr_error, data_out} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL aerr_mem got %b/%h exp 1/2", addr_error, data_out); end
        step(0, 1, 0, 32'h5, 0);
        n_cmp++; if ({data_valid, data_out} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL aerr_misaligned_rd got %b/%h exp 1/0", data_valid, data_out); end
    endtask

    task automatic test_reset_during_push();
        step(1, 0, 0, 32'h320, 32'h55);
        reset = 1'b1; step(1, 0, 1, 0, 32'h77);
        n_cmp++; if ({sp, addr_error} !== {6'd0, 1'b0}) begin n_fail++; $display("FAIL rst_push got %0d/%b exp 0/0", sp, addr_error); end
        step(0, 1, 0, 32'h320, 0);
        n_cmp++; if (data_out !== 32'h55) begin n_fail++; $display("FAIL rst_push_nowrite got %h exp 55", data_out); end
    endtask

    initial begin
        test_reset();
        test_static_read();
        test_static_write();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_push_pop_same();
        test_addr_error();
        test_reset_during_push();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_stack_unit.md
DATA_MEMORY_STACK_UNIT -- requirements
Module: data_memory_stack_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_WORDS, default 256, memory depth in words.
REQ-004 SHALL have parameter STACK_BASE, default 200, first stack word index.
REQ-005 SHALL have parameter STACK_WORDS, default 56, stack depth in words; STACK_BASE+STACK_WORDS <= MEM_WORDS.
REQ-006 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port mem_write  in  1  write/push request.
REQ-009 SHALL have port mem_read  in  1  read/pop request.
REQ-010 SHALL have port stack_en  in  1  1 = stack operation, 0 = static memory operation.
REQ-011 SHALL have port address  in  ADDR_W  byte address for static operations; ignored in stack mode.
REQ-012 SHALL have port data_in  in  DATA_W  write/push data.
REQ-013 SHALL have port err_clear  in  1  clears sticky error flags.
REQ-014 SHALL have port data_out  out  DATA_W  registered read/pop data.
REQ-015 SHALL have port data_valid  out  1  one-cycle pulse qualifying data_out.
REQ-016 SHALL have port sp  out  $clog2(STACK_WORDS+1)  stack occupancy in words.
REQ-017 SHALL have ports stack_full, stack_empty  out  1  combinational from sp.
REQ-018 SHALL have ports stack_overflow, stack_underflow, addr_error  out  1  sticky error flags.

Function
REQ-019 Word index SHALL be address[ADDR_W-1:2]; address[1:0] != 0 or index >= MEM_WORDS SHALL be an address error: no write, data_out = 0, data_valid still pulses, addr_error set.
REQ-020 Static write (stack_en=0, mem_write=1, mem_read=0) SHALL store data_in at the next edge; no data_valid.
REQ-021 Static read (stack_en=0, mem_read=1, mem_write=0) SHALL present the word on data_out with data_valid=1 exactly one cycle after the request edge.
REQ-022 Static read+write same cycle SHALL return the old contents (read-before-write) and store data_in.
REQ-023 Static accesses SHALL be permitted anywhere in 0..MEM_WORDS-1, including the stack region, without altering sp.
REQ-024 Push (stack_en=1, mem_write=1, mem_read=0) with sp < STACK_WORDS SHALL store data_in at word STACK_BASE+sp and increment sp.
REQ-025 Push when stack_full SHALL not write, hold sp, set stack_overflow.
REQ-026 Pop (stack_en=1, mem_read=1, mem_write=0) with sp > 0 SHALL decrement sp and return word STACK_BASE+sp-1 with data_valid one cycle later.
REQ-027 Pop when stack_empty SHALL hold sp, set stack_underflow, output data_out = 0 with data_valid=1.
REQ-028 Stack push+pop same cycle with sp > 0 SHALL replace the top word with data_in, return the old top with data_valid, sp unchanged; with sp = 0 SHALL behave as REQ-027 with no write.
REQ-029 Neither mem_read nor mem_write SHALL be a no-op; data_out SHALL hold its last value; data_valid = 0.
REQ-030 stack_full SHALL equal (sp == STACK_WORDS); stack_empty SHALL equal (sp == 0).
REQ-031 Error flags SHALL remain set until err_clear or reset; err_clear coincident with a new error SHALL leave the flag set.
REQ-032 Operations SHALL be accepted every cycle with no stall; back-to-back push/pop SHALL be single-cycle each.

Reset
REQ-033 reset SHALL, at the edge, set sp=0, data_out=0, data_valid=0, all error flags 0; reset overrides any concurrent request (no write, no pointer change).
REQ-034 Memory contents SHALL not be cleared by reset; at time zero words 0,1,2 SHALL hold 2,1,0, others undefined.

Verification
REQ-035 Reset, static read byte addr 0x4 -> next cycle data_out=1, data_valid=1; addr 0x8 -> 0.
REQ-036 Push 0xA,0xB,0xC -> sp=3; pop x3 -> data_out 0xC,0xB,0xA on consecutive cycles, sp=0, stack_empty=1.
REQ-037 Fill with 56 pushes -> stack_full=1; 57th push -> stack_overflow=1, sp=56, word 255 unchanged; err_clear -> flag 0.
REQ-038 Pop on empty -> stack_underflow=1, data_out=0, data_valid=1, sp=0.
REQ-039 sp=2 top=0x22, push+pop with data_in=0x33 -> data_out=0x22, sp=2; then pop -> 0x33.
REQ-040 Static write to addr 0x401 and 0x400 (index 256) -> addr_error=1, memory unchanged; reset during a push -> sp=0, no write.
